// File: rtl/mem_arbiter_if.sv
// Bus bundle between the pipeline memory ports, the arbiter and the memory.
// The arbiter connects through the slave modport; the surrounding pipeline/memory
// environment connects through the master modport.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-fetch port
    logic              imem_req_i;
    logic [ADDR_W-1:0] imem_addr_i;
    logic [1:0]        imem_size_i;
    logic              imem_ack_o;
    logic [DATA_W-1:0] imem_rd_data_o;
    // data port
    logic              dmem_req_i;
    logic              dmem_we_i;
    logic [ADDR_W-1:0] dmem_addr_i;
    logic [1:0]        dmem_size_i;
    logic [DATA_W-1:0] dmem_wr_data_i;
    logic              dmem_ack_o;
    logic [DATA_W-1:0] dmem_rd_data_o;
    // shared memory side
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [1:0]        mem_size_o;
    logic [DATA_W-1:0] mem_wr_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_rd_data_i;

    modport slave (
        input  imem_req_i, imem_addr_i, imem_size_i,
        output imem_ack_o, imem_rd_data_o,
        input  dmem_req_i, dmem_we_i, dmem_addr_i, dmem_size_i, dmem_wr_data_i,
        output dmem_ack_o, dmem_rd_data_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_size_o, mem_wr_data_o,
        input  mem_ack_i, mem_rd_data_i
    );

    modport master (
        output imem_req_i, imem_addr_i, imem_size_i,
        input  imem_ack_o, imem_rd_data_o,
        output dmem_req_i, dmem_we_i, dmem_addr_i, dmem_size_i, dmem_wr_data_i,
        input  dmem_ack_o, dmem_rd_data_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_size_o, mem_wr_data_o,
        output mem_ack_i, mem_rd_data_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch (imem) and data
// (dmem) ports with one transaction outstanding. dmem wins ties. Defining
// MEM_ARB_FAIRNESS_EN adds a saturating starve counter that forces an imem grant
// after STARVE_LIMIT consecutive dmem grants taken while imem was waiting.
// All outputs are registered; reset_i is synchronous and active-high.
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;          // 1 = dmem owns the access
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic [DATA_W-1:0] mem_wr_data_q, mem_wr_data_d;
    logic              imem_ack_q, imem_ack_d;
    logic              dmem_ack_q, dmem_ack_d;
    logic [DATA_W-1:0] imem_rd_data_q, imem_rd_data_d;
    logic [DATA_W-1:0] dmem_rd_data_q, dmem_rd_data_d;

    logic any_req;
    logic grant_dmem;

    assign any_req = bus.imem_req_i | bus.dmem_req_i;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;

    // Winner selection: dmem first unless imem has waited through STARVE_LIMIT dmem grants.
    always_comb begin
        if (bus.dmem_req_i && bus.imem_req_i && (starve_q == CNT_MAX)) begin
            grant_dmem = 1'b0;
        end else begin
            grant_dmem = bus.dmem_req_i;
        end
    end

    // Starve counter: count dmem grants that bypass a waiting imem, clear otherwise.
    always_comb begin
        starve_d = starve_q;
        if ((state_q == ST_IDLE) && any_req) begin
            if (grant_dmem && bus.imem_req_i) begin
                if (starve_q != CNT_MAX) begin
                    starve_d = starve_q + CNT_W'(1);
                end else begin
                    starve_d = starve_q;
                end
            end else begin
                starve_d = '0;
            end
        end else begin
            starve_d = starve_q;
        end
    end

    // Starve counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Winner selection: strict dmem priority (the older instruction).
    always_comb begin
        grant_dmem = bus.dmem_req_i;
    end
`endif

    // State and datapath registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            owner_q        <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_size_q     <= 2'd0;
            mem_wr_data_q  <= '0;
            imem_ack_q     <= 1'b0;
            dmem_ack_q     <= 1'b0;
            imem_rd_data_q <= '0;
            dmem_rd_data_q <= '0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_size_q     <= mem_size_d;
            mem_wr_data_q  <= mem_wr_data_d;
            imem_ack_q     <= imem_ack_d;
            dmem_ack_q     <= dmem_ack_d;
            imem_rd_data_q <= imem_rd_data_d;
            dmem_rd_data_q <= dmem_rd_data_d;
        end
    end

    // Next-state: grant from IDLE, wait for memory in ISSUE, single response cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ack_i) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs: latch the winner at grant, capture read data on mem ack, pulse the owner's ack.
    // Requests are not looked at outside IDLE and mem_ack_i only matters in ISSUE.
    always_comb begin
        owner_d        = owner_q;
        mem_req_d      = mem_req_q;
        mem_we_d       = mem_we_q;
        mem_addr_d     = mem_addr_q;
        mem_size_d     = mem_size_q;
        mem_wr_data_d  = mem_wr_data_q;
        imem_ack_d     = 1'b0;
        dmem_ack_d     = 1'b0;
        imem_rd_data_d = imem_rd_data_q;
        dmem_rd_data_d = dmem_rd_data_q;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d   = grant_dmem;
                    mem_req_d = 1'b1;
                    if (grant_dmem) begin
                        mem_we_d      = bus.dmem_we_i;
                        mem_addr_d    = bus.dmem_addr_i;
                        mem_size_d    = bus.dmem_size_i;
                        mem_wr_data_d = bus.dmem_wr_data_i;
                    end else begin
                        mem_we_d      = 1'b0;
                        mem_addr_d    = bus.imem_addr_i;
                        mem_size_d    = bus.imem_size_i;
                        mem_wr_data_d = '0;
                    end
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (bus.mem_ack_i) begin
                    mem_req_d = 1'b0;
                    if (owner_q) begin
                        dmem_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            dmem_rd_data_d = bus.mem_rd_data_i;
                        end else begin
                            dmem_rd_data_d = dmem_rd_data_q;
                        end
                    end else begin
                        imem_ack_d     = 1'b1;
                        imem_rd_data_d = bus.mem_rd_data_i;
                    end
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_RESP: begin
                mem_req_d = 1'b0;
            end
            default: begin
                mem_req_d = 1'b0;
            end
        endcase
    end

    assign bus.mem_req_o      = mem_req_q;
    assign bus.mem_we_o       = mem_we_q;
    assign bus.mem_addr_o     = mem_addr_q;
    assign bus.mem_size_o     = mem_size_q;
    assign bus.mem_wr_data_o  = mem_wr_data_q;
    assign bus.imem_ack_o     = imem_ack_q;
    assign bus.dmem_ack_o     = dmem_ack_q;
    assign bus.imem_rd_data_o = imem_rd_data_q;
    assign bus.dmem_rd_data_o = dmem_rd_data_q;

endmodule
